// File: rtl/fft_cmult_pipe.sv
// Four-stage pipelined complex twiddle multiplier with round/scale and bubble-collapsing handshake.
// Optional output saturation and overflow flag: define FFT_CMULT_SAT_EN.
module fft_cmult_pipe #(
  parameter int DATA_W = 25,
  parameter int TW_W   = 18,
  parameter int OUT_W  = 25,
  parameter int SHIFT  = 17
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2*DATA_W-1:0]  stage_i,
  input  logic [2*TW_W-1:0]    w_i,
  input  logic                 conj_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*OUT_W-1:0]   butterfly_stage_o,
  output logic                 ovf_o
);

  localparam int W_P = DATA_W + TW_W;
  localparam int W_S = W_P + 1;
  localparam int W_T = W_S + 1;

  localparam logic signed [W_T-1:0] RND = W_T'(1) <<< (SHIFT - 1);

  logic v1_q, v2_q, v3_q, v4_q;
  logic v1_d, v2_d, v3_d, v4_d;
  logic ld1, ld2, ld3, ld4, drain;

  logic signed [DATA_W-1:0] ar_q, ai_q, ar_d, ai_d;
  logic signed [TW_W-1:0]   br_q, bi_q, br_d, bi_d;
  logic                     cj1_q, cj1_d, cj2_q, cj2_d;

  logic signed [W_P-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [W_P-1:0] rr_d, ii_d, ri_d, ir_d;

  logic signed [W_S-1:0] sre_q, sim_q, sre_d, sim_d;
  logic signed [W_T-1:0] t_re, t_im;

  logic signed [OUT_W-1:0] yre_q, yim_q, yre_d, yim_d;

  // Load chain resolved from the output back, so any bubble is filled.
  assign drain   = v4_q & ready_i;
  assign ld4     = v3_q & (~v4_q | drain);
  assign ld3     = v2_q & (~v3_q | ld4);
  assign ld2     = v1_q & (~v2_q | ld3);
  assign ready_o = ~v1_q | ld2;
  assign ld1     = valid_i & ready_o;

  function automatic logic signed [W_T-1:0] rnd_scale(
    input logic signed [W_S-1:0] s
  );
    logic signed [W_T-1:0] t;
    t = {s[W_S-1], s};
    t = t + RND;
    return t >>> SHIFT;
  endfunction

  assign t_re = rnd_scale(sre_q);
  assign t_im = rnd_scale(sim_q);

  always_comb begin
    v1_d = ld1 | (v1_q & ~ld2);
    v2_d = ld2 | (v2_q & ~ld3);
    v3_d = ld3 | (v3_q & ~ld4);
    v4_d = ld4 | (v4_q & ~drain);

    ar_d  = ar_q;
    ai_d  = ai_q;
    br_d  = br_q;
    bi_d  = bi_q;
    cj1_d = cj1_q;
    if (ld1) begin
      ar_d  = stage_i[2*DATA_W-1:DATA_W];
      ai_d  = stage_i[DATA_W-1:0];
      br_d  = w_i[2*TW_W-1:TW_W];
      bi_d  = w_i[TW_W-1:0];
      cj1_d = conj_i;
    end

    rr_d  = rr_q;
    ii_d  = ii_q;
    ri_d  = ri_q;
    ir_d  = ir_q;
    cj2_d = cj2_q;
    if (ld2) begin
      rr_d  = W_P'(ar_q) * W_P'(br_q);
      ii_d  = W_P'(ai_q) * W_P'(bi_q);
      ri_d  = W_P'(ar_q) * W_P'(bi_q);
      ir_d  = W_P'(ai_q) * W_P'(br_q);
      cj2_d = cj1_q;
    end

    sre_d = sre_q;
    sim_d = sim_q;
    if (ld3) begin
      if (cj2_q) begin
        sre_d = W_S'(rr_q) + W_S'(ii_q);
        sim_d = W_S'(ir_q) - W_S'(ri_q);
      end else begin
        sre_d = W_S'(rr_q) - W_S'(ii_q);
        sim_d = W_S'(ri_q) + W_S'(ir_q);
      end
    end
  end

`ifdef FFT_CMULT_SAT_EN
  localparam logic signed [W_T-1:0] OMAX =
    {{(W_T-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W_T-1:0] OMIN =
    {{(W_T-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic ovf_q, ovf_d;

  always_comb begin
    yre_d = yre_q;
    yim_d = yim_q;
    ovf_d = ovf_q;
    if (ld4) begin
      ovf_d = 1'b0;
      yre_d = t_re[OUT_W-1:0];
      yim_d = t_im[OUT_W-1:0];
      if (t_re > OMAX) begin
        yre_d = OMAX[OUT_W-1:0];
        ovf_d = 1'b1;
      end else if (t_re < OMIN) begin
        yre_d = OMIN[OUT_W-1:0];
        ovf_d = 1'b1;
      end
      if (t_im > OMAX) begin
        yim_d = OMAX[OUT_W-1:0];
        ovf_d = 1'b1;
      end else if (t_im < OMIN) begin
        yim_d = OMIN[OUT_W-1:0];
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  always_comb begin
    yre_d = yre_q;
    yim_d = yim_q;
    if (ld4) begin
      yre_d = t_re[OUT_W-1:0];
      yim_d = t_im[OUT_W-1:0];
    end
  end

  assign ovf_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      ar_q  <= '0;
      ai_q  <= '0;
      br_q  <= '0;
      bi_q  <= '0;
      cj1_q <= 1'b0;
      rr_q  <= '0;
      ii_q  <= '0;
      ri_q  <= '0;
      ir_q  <= '0;
      cj2_q <= 1'b0;
      sre_q <= '0;
      sim_q <= '0;
      yre_q <= '0;
      yim_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      v4_q  <= v4_d;
      ar_q  <= ar_d;
      ai_q  <= ai_d;
      br_q  <= br_d;
      bi_q  <= bi_d;
      cj1_q <= cj1_d;
      rr_q  <= rr_d;
      ii_q  <= ii_d;
      ri_q  <= ri_d;
      ir_q  <= ir_d;
      cj2_q <= cj2_d;
      sre_q <= sre_d;
      sim_q <= sim_d;
      yre_q <= yre_d;
      yim_q <= yim_d;
    end
  end

  assign valid_o           = v4_q;
  assign butterfly_stage_o = {yre_q, yim_q};

endmodule

// File: tb/tb_fft_cmult_pipe.sv
// Directed bench for fft_cmult_pipe: arithmetic, rounding, overflow,
// backpressure and mid-stream reset, with hand-computed expectations.
module tb_fft_cmult_pipe;

  localparam int DATA_W = 25;
  localparam int TW_W   = 18;
  localparam int OUT_W  = 25;

  logic                clk_i;
  logic                rst_i;
  logic                valid_i;
  logic                ready_o;
  logic [2*DATA_W-1:0] stage_i;
  logic [2*TW_W-1:0]   w_i;
  logic                conj_i;
  logic                valid_o;
  logic                ready_i;
  logic [2*OUT_W-1:0]  butterfly_stage_o;
  logic                ovf_o;

  logic signed [OUT_W-1:0] y_re, y_im;
  assign y_re = butterfly_stage_o[2*OUT_W-1:OUT_W];
  assign y_im = butterfly_stage_o[OUT_W-1:0];

  int n_vec = 0;
  int n_bad = 0;

  fft_cmult_pipe dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .stage_i           (stage_i),
    .w_i               (w_i),
    .conj_i            (conj_i),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .butterfly_stage_o (butterfly_stage_o),
    .ovf_o             (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int ar, input int ai, input int wr,
                       input int wi, input bit cj);
    stage_i = {DATA_W'(ar), DATA_W'(ai)};
    w_i     = {TW_W'(wr), TW_W'(wi)};
    conj_i  = cj;
  endtask

  task automatic run_one(input string tag, input int ar, input int ai,
                         input int wr, input int wi, input bit cj,
                         input int er, input int ei, input int eo);
    int lat;
    drive(ar, ai, wr, wi, cj);
    valid_i = 1'b1;
    #1;
    chk({tag, "_rdy"}, int'(ready_o), 1);
    step();
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_re"}, int'(y_re), er);
    chk({tag, "_im"}, int'(y_im), ei);
    chk({tag, "_ovf"}, int'(ovf_o), eo);
    step();
  endtask

  int  q_re[$];
  int  q_im[$];
  int  sent, rx, occ, lat;
  bit  acc, drn, stall_prev, saw_full;
  int  prev_re, prev_im;

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    stage_i = '0;
    w_i     = '0;
    conj_i  = 1'b0;
    step();
    step();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_re", int'(y_re), 0);
    chk("rst_im", int'(y_im), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    rst_i = 1'b1;
    step();
    chk("idle_ready", int'(ready_o), 1);

    run_one("neg", 1000, -2000, -131072, 0, 1'b0, -1000, 2000, 0);

    // Conj vs normal, issued on consecutive cycles.
    drive(1000, 0, 0, -131072, 1'b0);
    valid_i = 1'b1;
    step();
    drive(1000, 0, 0, -131072, 1'b1);
    step();
    valid_i = 1'b0;
    lat = 2;
    while (!valid_o && lat < 20) begin
      step();
      lat++;
    end
    chk("b2b_lat", lat, 4);
    chk("nconj_re", int'(y_re), 0);
    chk("nconj_im", int'(y_im), -1000);
    step();
    chk("conj_valid", int'(valid_o), 1);
    chk("conj_re", int'(y_re), 0);
    chk("conj_im", int'(y_im), 1000);
    step();
    chk("b2b_empty", int'(valid_o), 0);

    run_one("rnd_pos", 3, 0, 65536, 0, 1'b0, 2, 0, 0);
    run_one("rnd_neg", -3, 0, 65536, 0, 1'b0, -1, 0, 0);

`ifdef FFT_CMULT_SAT_EN
    run_one("ovf", -16777216, -16777216, -131072, -131072, 1'b0,
            0, 16777215, 1);
`else
    run_one("ovf", -16777216, -16777216, -131072, -131072, 1'b0,
            0, 0, 0);
`endif

    // Backpressure: 8-sample stream, ready_i low for cycles 6..8.
    sent = 0;
    rx = 0;
    occ = 0;
    stall_prev = 1'b0;
    saw_full = 1'b0;
    prev_re = 0;
    prev_im = 0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      ready_i = !(c >= 6 && c <= 8);
      if (sent < 8) begin
        drive(100 * (sent + 1), sent + 1, -131072, 0, 1'b0);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      acc = valid_i && ready_o;
      drn = valid_o && ready_i;
      if (!ready_o) saw_full = 1'b1;
      chk("bp_ready", int'(ready_o), int'(!(occ == 4 && !ready_i)));
      if (valid_o) begin
        if (q_re.size() > 0) begin
          chk("bp_re", int'(y_re), q_re[0]);
          chk("bp_im", int'(y_im), q_im[0]);
        end else begin
          chk("bp_extra", 1, 0);
        end
        if (stall_prev) begin
          chk("bp_hold_re", int'(y_re), prev_re);
          chk("bp_hold_im", int'(y_im), prev_im);
        end
      end
      stall_prev = valid_o && !ready_i;
      prev_re = int'(y_re);
      prev_im = int'(y_im);
      if (acc) begin
        q_re.push_back(-100 * (sent + 1));
        q_im.push_back(-(sent + 1));
        sent++;
      end
      if (drn) begin
        void'(q_re.pop_front());
        void'(q_im.pop_front());
        rx++;
      end
      occ = occ + int'(acc) - int'(drn);
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("bp_count", rx, 8);
    chk("bp_full_seen", int'(saw_full), 1);
    step();
    chk("bp_drained", int'(valid_o), 0);

    // Reset with three samples in flight.
    for (int k = 0; k < 3; k++) begin
      drive(500 + k, 0, -131072, 0, 1'b0);
      valid_i = 1'b1;
      step();
    end
    valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_valid", int'(valid_o), 0);
    chk("arst_re", int'(y_re), 0);
    step();
    step();
    rst_i = 1'b1;
    step();
    chk("post_rst_idle", int'(valid_o), 0);
    run_one("post_rst", 7, -9, -131072, 0, 1'b0, -7, 9, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
